snes_pad_poller: RTL and testbench

//   Initiator side of the SNES controller serial link for the spacewar game. It generates the

---
 rtl/snes_pad_poller.sv | 170 +++++++++++++++++
 tb/tb_snes_pad_poller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_poller.sv
`default_nettype none
// ============================================================================
// snes_pad_poller : SNES two-pad latch/clock initiator with 16-bit shift-in,
//                   pad-presence detection and active-high button decode.
// Revision 1.0
// ============================================================================
module snes_pad_poller #(
  parameter int LATCH_CYCLES    = 300,
  parameter int HALF_BIT_CYCLES = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  pad_data_i,
  output logic        pad_latch_o,
  output logic        pad_clk_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [11:0] p1_buttons_o,
  output logic [11:0] p2_buttons_o,
  output logic        p1_present_o,
  output logic        p2_present_o
);

  localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CLK_HI = 3'd2,
    S_CLK_LO = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    meta_q, sync_q;
  logic [15:0]   raw1_q, raw1_d, raw2_q, raw2_d;
  logic          pad_latch_q, pad_latch_d;
  logic          pad_clk_q, pad_clk_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [11:0]   p1_buttons_q, p1_buttons_d, p2_buttons_q, p2_buttons_d;
  logic          p1_present_q, p1_present_d, p2_present_q, p2_present_d;

  // The top nibble always reads released on a real pad; a pulled-low absent pad reads zeros.
  function automatic logic [12:0] decode(input logic [15:0] r);
    logic present;
    present = (r[15:12] == 4'hF);
    return {present, present ? ~r[11:0] : 12'h000};
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    raw1_d       = raw1_q;
    raw2_d       = raw2_q;
    p1_buttons_d = p1_buttons_q;
    p2_buttons_d = p2_buttons_q;
    p1_present_d = p1_present_q;
    p2_present_d = p2_present_q;
    valid_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LATCH;
          cnt_d   = '0;
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_CLK_HI;
          cnt_d   = '0;
          idx_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CLK_HI: begin
        if (cnt_q == HALF_LAST) begin
          raw1_d[idx_q] = sync_q[0];
          raw2_d[idx_q] = sync_q[1];
          state_d       = S_CLK_LO;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CLK_LO: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_CLK_HI;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        {p1_present_d, p1_buttons_d} = decode(raw1_q);
        {p2_present_d, p2_buttons_d} = decode(raw2_q);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pad-facing strobes follow the next state so the pad sees each phase for its full length.
    pad_latch_d = (state_d == S_LATCH);
    pad_clk_d   = (state_d != S_CLK_LO);
    busy_d      = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 4'd0;
      meta_q       <= 2'b00;
      sync_q       <= 2'b00;
      raw1_q       <= 16'h0000;
      raw2_q       <= 16'h0000;
      pad_latch_q  <= 1'b0;
      pad_clk_q    <= 1'b1;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      p1_buttons_q <= 12'h000;
      p2_buttons_q <= 12'h000;
      p1_present_q <= 1'b0;
      p2_present_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      meta_q       <= pad_data_i;
      sync_q       <= meta_q;
      raw1_q       <= raw1_d;
      raw2_q       <= raw2_d;
      pad_latch_q  <= pad_latch_d;
      pad_clk_q    <= pad_clk_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      p1_buttons_q <= p1_buttons_d;
      p2_buttons_q <= p2_buttons_d;
      p1_present_q <= p1_present_d;
      p2_present_q <= p2_present_d;
    end
  end

  assign pad_latch_o  = pad_latch_q;
  assign pad_clk_o    = pad_clk_q;
  assign busy_o       = busy_q;
  assign valid_o      = valid_q;
  assign p1_buttons_o = p1_buttons_q;
  assign p2_buttons_o = p2_buttons_q;
  assign p1_present_o = p1_present_q;
  assign p2_present_o = p2_present_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_pad_poller.sv
`default_nettype none
// ============================================================================
// tb_snes_pad_poller : directed bench with two behavioural SNES pad models.
// Revision 1.0
// ============================================================================
module tb_snes_pad_poller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  pad_data;
  logic        pad_latch, pad_clk, busy, valid;
  logic [11:0] p1_buttons, p2_buttons;
  logic        p1_present, p2_present;

  logic [15:0] raw1, raw2, sr1, sr2;
  logic        p2_absent;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  snes_pad_poller #(.LATCH_CYCLES(6), .HALF_BIT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .pad_data_i   (pad_data),
    .pad_latch_o  (pad_latch),
    .pad_clk_o    (pad_clk),
    .busy_o       (busy),
    .valid_o      (valid),
    .p1_buttons_o (p1_buttons),
    .p2_buttons_o (p2_buttons),
    .p1_present_o (p1_present),
    .p2_present_o (p2_present)
  );

  // Pad model: parallel load while latched, shift toward bit 0 on each pad_clk rise.
  always @(posedge pad_latch) begin
    sr1 = raw1;
    sr2 = raw2;
  end
  always @(posedge pad_clk) begin
    if (!pad_latch) begin
      sr1 = {1'b1, sr1[15:1]};
      sr2 = {1'b1, sr2[15:1]};
    end
  end
  assign pad_data = {(p2_absent ? 1'b0 : sr2[0]), sr1[0]};

  task automatic run_poll(input int e1, input int e2, output int lat, output int nvalid,
                          output int latch_cyc, output int low_cyc, output int pulses,
                          output int busy_gaps, output int early_changes);
    logic        prev_clk;
    logic [25:0] snap;
    int          c;
    lat = -1; nvalid = 0; latch_cyc = 0; low_cyc = 0; pulses = 0; busy_gaps = 0;
    early_changes = 0;
    prev_clk = 1'b1;
    @(negedge clk);
    snap  = {p1_present, p2_present, p1_buttons, p2_buttons};
    start = 1'b1;
    for (int n = 1; n <= 145; n++) begin
      @(negedge clk);
      c = n - 1;
      start = (c == e1) || (c == e2);
      if (valid) begin
        nvalid++;
        if (lat < 0) lat = c;
      end
      if (pad_latch) latch_cyc++;
      if (!pad_clk) low_cyc++;
      if (prev_clk && !pad_clk) pulses++;
      prev_clk = pad_clk;
      if (c <= 135 && !busy) busy_gaps++;
      if (lat < 0 && {p1_present, p2_present, p1_buttons, p2_buttons} !== snap) early_changes++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; p2_absent = 1'b0; raw1 = 16'hFFFF; raw2 = 16'hFFFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL reset pad_latch: got %b expected 0", pad_latch); end
    n_checks++; if (pad_clk !== 1'b1) begin n_fail++; $display("FAIL reset pad_clk: got %b expected 1", pad_clk); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b expected 0", valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (p1_buttons !== 12'h000) begin n_fail++; $display("FAIL reset p1_buttons: got %h expected 000", p1_buttons); end
    n_checks++; if (p2_buttons !== 12'h000) begin n_fail++; $display("FAIL reset p2_buttons: got %h expected 000", p2_buttons); end
    n_checks++; if (p1_present !== 1'b0) begin n_fail++; $display("FAIL reset p1_present: got %b expected 0", p1_present); end
    n_checks++; if (p2_present !== 1'b0) begin n_fail++; $display("FAIL reset p2_present: got %b expected 0", p2_present); end
  endtask

  task automatic test_basic_poll;
    int lat, nv, lc, lo, pu, bg, ec;
    raw1 = 16'hFFFE; raw2 = 16'hF7FF; p2_absent = 1'b0;
    run_poll(-1, -1, lat, nv, lc, lo, pu, bg, ec);
    n_checks++; if (lat !== 135) begin n_fail++; $display("FAIL basic latency: got %0d expected 135", lat); end
    n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL basic valid_count: got %0d expected 1", nv); end
    n_checks++; if (lc !== 6) begin n_fail++; $display("FAIL basic latch_cycles: got %0d expected 6", lc); end
    n_checks++; if (pu !== 16) begin n_fail++; $display("FAIL basic clk_pulses: got %0d expected 16", pu); end
    n_checks++; if (lo !== 64) begin n_fail++; $display("FAIL basic clk_low_cycles: got %0d expected 64", lo); end
    n_checks++; if (bg !== 0) begin n_fail++; $display("FAIL basic busy_gaps: got %0d expected 0", bg); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic busy_after: got %b expected 0", busy); end
    n_checks++; if (p1_buttons !== 12'h001) begin n_fail++; $display("FAIL basic p1_buttons: got %h expected 001", p1_buttons); end
    n_checks++; if (p2_buttons !== 12'h800) begin n_fail++; $display("FAIL basic p2_buttons: got %h expected 800", p2_buttons); end
    n_checks++; if (p1_present !== 1'b1) begin n_fail++; $display("FAIL basic p1_present: got %b expected 1", p1_present); end
    n_checks++; if (p2_present !== 1'b1) begin n_fail++; $display("FAIL basic p2_present: got %b expected 1", p2_present); end
  endtask

  task automatic test_absent_pad;
    int lat, nv, lc, lo, pu, bg, ec;
    raw1 = 16'hF0F0; raw2 = 16'hFFFF; p2_absent = 1'b1;
    run_poll(-1, -1, lat, nv, lc, lo, pu, bg, ec);
    n_checks++; if (lat !== 135) begin n_fail++; $display("FAIL absent latency: got %0d expected 135", lat); end
    n_checks++; if (p1_buttons !== 12'hF0F) begin n_fail++; $display("FAIL absent p1_buttons: got %h expected F0F", p1_buttons); end
    n_checks++; if (p1_present !== 1'b1) begin n_fail++; $display("FAIL absent p1_present: got %b expected 1", p1_present); end
    n_checks++; if (p2_buttons !== 12'h000) begin n_fail++; $display("FAIL absent p2_buttons: got %h expected 000", p2_buttons); end
    n_checks++; if (p2_present !== 1'b0) begin n_fail++; $display("FAIL absent p2_present: got %b expected 0", p2_present); end
    p2_absent = 1'b0;
  endtask

  task automatic test_start_while_busy;
    int lat, nv, lc, lo, pu, bg, ec;
    raw1 = 16'hFAAA; raw2 = 16'hF555;
    run_poll(10, 50, lat, nv, lc, lo, pu, bg, ec);
    n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL busy_start valid_count: got %0d expected 1", nv); end
    n_checks++; if (lat !== 135) begin n_fail++; $display("FAIL busy_start latency: got %0d expected 135", lat); end
    n_checks++; if (bg !== 0) begin n_fail++; $display("FAIL busy_start busy_gaps: got %0d expected 0", bg); end
    n_checks++; if (ec !== 0) begin n_fail++; $display("FAIL busy_start early_changes: got %0d expected 0", ec); end
    n_checks++; if (p1_buttons !== 12'h555) begin n_fail++; $display("FAIL busy_start p1_buttons: got %h expected 555", p1_buttons); end
    n_checks++; if (p2_buttons !== 12'hAAA) begin n_fail++; $display("FAIL busy_start p2_buttons: got %h expected AAA", p2_buttons); end
  endtask

  task automatic test_async_reset;
    int lat, nv, lc, lo, pu, bg, ec;
    raw1 = 16'h0000; raw2 = 16'h0000;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 71; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst busy: got %b expected 0", busy); end
    n_checks++; if (pad_clk !== 1'b1) begin n_fail++; $display("FAIL async_rst pad_clk: got %b expected 1", pad_clk); end
    n_checks++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL async_rst pad_latch: got %b expected 0", pad_latch); end
    n_checks++; if (p1_buttons !== 12'h000) begin n_fail++; $display("FAIL async_rst p1_buttons: got %h expected 000", p1_buttons); end
    n_checks++; if (p2_buttons !== 12'h000) begin n_fail++; $display("FAIL async_rst p2_buttons: got %h expected 000", p2_buttons); end
    n_checks++; if (p1_present !== 1'b0 || p2_present !== 1'b0) begin n_fail++; $display("FAIL async_rst present: got %b%b expected 00", p1_present, p2_present); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    raw1 = 16'hF123; raw2 = 16'hFFFF;
    run_poll(-1, -1, lat, nv, lc, lo, pu, bg, ec);
    n_checks++; if (lat !== 135) begin n_fail++; $display("FAIL post_rst latency: got %0d expected 135", lat); end
    n_checks++; if (p1_buttons !== 12'hEDC) begin n_fail++; $display("FAIL post_rst p1_buttons: got %h expected EDC", p1_buttons); end
    n_checks++; if (p2_buttons !== 12'h000) begin n_fail++; $display("FAIL post_rst p2_buttons: got %h expected 000", p2_buttons); end
    n_checks++; if (p1_present !== 1'b1 || p2_present !== 1'b1) begin n_fail++; $display("FAIL post_rst present: got %b%b expected 11", p1_present, p2_present); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r1 [3];
    logic [15:0] r2 [3];
    logic [12:0] e1 [3];
    logic [12:0] e2 [3];
    int vcount, last, c, extra;
    r1[0] = 16'hFF00; e1[0] = {1'b1, 12'h0FF};
    r2[0] = 16'hF00F; e2[0] = {1'b1, 12'hFF0};
    r1[1] = 16'h0FFF; e1[1] = {1'b0, 12'h000};
    r2[1] = 16'hF000; e2[1] = {1'b1, 12'hFFF};
    r1[2] = 16'hFFFF; e1[2] = {1'b1, 12'h000};
    r2[2] = 16'h7000; e2[2] = {1'b0, 12'h000};
    raw1 = r1[0]; raw2 = r2[0];
    vcount = 0; last = -1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 600 && vcount < 3; n++) begin
      @(negedge clk);
      c = n - 1;
      if (valid) begin
        n_checks++; if ({p1_present, p1_buttons} !== e1[vcount]) begin n_fail++; $display("FAIL b2b p1 poll%0d: got %h expected %h", vcount, {p1_present, p1_buttons}, e1[vcount]); end
        n_checks++; if ({p2_present, p2_buttons} !== e2[vcount]) begin n_fail++; $display("FAIL b2b p2 poll%0d: got %h expected %h", vcount, {p2_present, p2_buttons}, e2[vcount]); end
        n_checks++;
        if (vcount == 0) begin
          if (c !== 135) begin n_fail++; $display("FAIL b2b first_latency: got %0d expected 135", c); end
        end else if (c - last !== 136) begin
          n_fail++; $display("FAIL b2b spacing poll%0d: got %0d expected 136", vcount, c - last);
        end
        last = c;
        vcount++;
        if (vcount < 3) begin
          raw1 = r1[vcount]; raw2 = r2[vcount];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_checks++; if (vcount !== 3) begin n_fail++; $display("FAIL b2b poll_count: got %0d expected 3", vcount); end
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (valid) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b extra_valids: got %0d expected 0", extra); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b busy_idle: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic_poll();
    test_absent_pad();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
